game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the rhythm game. It steps the design through IDLE, COUNTDOWN, PLAY and RESULT using the debounced start/restart pulses and the note generator's end flag. It issues a synchronous clear and a run enable to the timer, note and score logic. It also arbitrates the single piezo between countdown/game-over beeps and the judgement hit sound, and sits between `button_ctrl`/`judgement_ctrl` and `piezo_ctrl`.

## Interface
Parameters:
- `COUNT_STEPS`, default 3: countdown digits shown (N..1).
- `COUNT_MS`, default 1000: ticks per countdown digit.
- `BEEP_MS`, default 100: beep length at the start of each digit.
- `GO_MS`, default 500: game-over tone length on entering RESULT.
- `BEEP_LIMIT`, default 47801: piezo half-period count for the countdown beep (~523 Hz at 50 MHz).
- `GO_LIMIT`, default 23900: piezo half-period count for the game-over tone (~1046 Hz).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `i_tick` in 1: 1 ms single-cycle tick from `clk_div`.
- `i_start` in 1: single-cycle start pulse.
- `i_restart` in 1: single-cycle restart pulse.
- `i_game_end` in 1: level, chart finished, from `note_gen`.
- `i_play_en` in 1: hit-sound enable from `judgement_ctrl`.
- `i_cnt_limit` in 32: hit-sound half-period from `judgement_ctrl`.
- `o_state` out 2: 0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=RESULT.
- `o_run` out 1: high only in PLAY; gates `game_timer` and note flow.
- `o_clear` out 1: one-cycle synchronous clear for the timer, note generator and score.
- `o_digit` out 4: current countdown digit; 0 outside COUNTDOWN.
- `o_piezo_en` out 1: arbitrated enable to `piezo_ctrl`.
- `o_piezo_limit` out 32: arbitrated half-period to `piezo_ctrl`.

## Operation
- **Reset.** State IDLE. All outputs are 0. The internal ms counter and GO counter are 0.
- **IDLE.**
  - `i_start` or `i_restart` causes entry to COUNTDOWN.
  - Otherwise hold. Piezo is silent.
- **Entry to COUNTDOWN** (from any state) does all of the following on the same edge:
  - `o_clear` <= 1 for exactly one cycle.
  - `o_digit` <= COUNT_STEPS.
  - ms counter <= 0.
  - `o_run` <= 0.
- **COUNTDOWN.**
  - Each `i_tick` increments the ms counter.
  - When the counter is COUNT_MS-1 on a tick:
    - It wraps to 0.
    - If `o_digit` > 1, `o_digit` decrements.
    - If `o_digit` = 1, the state goes to PLAY, `o_digit` <= 0 and `o_run` <= 1.
  - `i_restart` re-enters COUNTDOWN (full reload plus clear).
  - `i_start` is ignored.
- **PLAY.**
  - `o_run` = 1.
  - `i_restart` causes entry to COUNTDOWN.
  - Otherwise, `i_game_end` = 1 moves the state to RESULT, sets `o_run` <= 0 and loads the GO counter with GO_MS.
  - `i_start` is ignored.
- **RESULT.**
  - Each `i_tick` decrements the GO counter until it reaches 0.
  - `i_start` or `i_restart` causes entry to COUNTDOWN.
- **Priority.**
  - `i_restart` has priority over `i_game_end` and over the tick-driven transitions in the same cycle.
  - `i_start` together with `i_restart` behaves as a single restart.
- **Piezo arbitration.** Sources are computed from the current state and counters:
  - COUNTDOWN: enable = (ms counter < BEEP_MS), limit = BEEP_LIMIT.
  - PLAY: enable = `i_play_en`, limit = `i_cnt_limit` (pass-through).
  - RESULT: enable = (GO counter != 0), limit = GO_LIMIT.
  - IDLE: enable = 0, limit = 0.
  - Whenever enable = 0, `o_piezo_limit` is driven to 0.
- **`i_game_end` sampling.** It is sampled only in PLAY. A stale high level during COUNTDOWN is ignored, because the note generator is cleared on entry.

## Timing
- All outputs are registered, and every state change takes effect on the edge that samples its cause.
- `o_clear` is high in the first cycle of COUNTDOWN only. A restart issued while in COUNTDOWN produces a fresh one-cycle pulse.
- Countdown length: PLAY is entered on the edge sampling the (COUNT_STEPS × COUNT_MS)-th tick after COUNTDOWN entry. Ticks in the entry cycle are not counted.
- `o_digit` changes on the tick edges that sample ticks COUNT_MS, 2·COUNT_MS, …
- Piezo outputs lag their source (state, counters, `i_play_en`/`i_cnt_limit`) by one cycle.
- PLAY to RESULT: `o_run` falls on the same edge that samples `i_game_end`.
- The GO tone ends on the edge sampling the GO_MS-th tick after entry.
- Reset during any state returns to IDLE on the next edge, with all outputs 0 and no `o_clear` pulse.

## Test plan
Parameter set for the bench: COUNT_STEPS=3, COUNT_MS=10, BEEP_MS=2, GO_MS=5, BEEP_LIMIT=100, GO_LIMIT=50.

1. **Start from IDLE.** Reset, then pulse `i_start` → `o_state`=1, `o_clear` high for 1 cycle, `o_digit`=3. After 10 ticks `o_digit`=2, after 20 ticks 1, after 30 ticks `o_state`=2, `o_run`=1, `o_digit`=0.
2. **Countdown beep.** In COUNTDOWN, `o_piezo_en`=1 with limit 100 for ms counter 0..1 of each digit, and `o_piezo_en`=0 with limit 0 for 2..9. The pattern appears 3 times.
3. **Hit-sound pass-through.** In PLAY, drive `i_play_en`=1 with `i_cnt_limit`=12345 → one cycle later `o_piezo_en`=1 and `o_piezo_limit`=12345. Drop `i_play_en` → en=0 and limit=0 one cycle later.
4. **Game end.** In PLAY, assert `i_game_end` → `o_state`=3 and `o_run`=0 on the next edge. Piezo plays limit 50 for 5 ticks, then goes silent. A further `i_start` → COUNTDOWN with a clear pulse.
5. **Simultaneous events.** In PLAY, assert `i_restart` and `i_game_end` in the same cycle → `o_state`=1 (not 3), with one `o_clear` pulse. `i_start` in COUNTDOWN or PLAY → no change.
6. **Reset mid-operation.** Assert `rst` during COUNTDOWN with `o_digit`=2 → next cycle `o_state`=0 and all outputs 0. `i_game_end` held high while in COUNTDOWN → it stays in COUNTDOWN.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Rhythm-game sequencer: IDLE -> COUNTDOWN -> PLAY -> RESULT.
// Also arbitrates the shared piezo between the sequencer tones and the judgement hit sound.
module game_flow_ctrl #(
   parameter int unsigned COUNT_STEPS = 3,
   parameter int unsigned COUNT_MS    = 1000,
   parameter int unsigned BEEP_MS     = 100,
   parameter int unsigned GO_MS       = 500,
   parameter int unsigned BEEP_LIMIT  = 47801,
   parameter int unsigned GO_LIMIT    = 23900
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_start,
   input  logic        i_restart,
   input  logic        i_game_end,
   input  logic        i_play_en,
   input  logic [31:0] i_cnt_limit,
   output logic [1:0]  o_state,
   output logic        o_run,
   output logic        o_clear,
   output logic [3:0]  o_digit,
   output logic        o_piezo_en,
   output logic [31:0] o_piezo_limit
);

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StCountdown = 2'd1,
      StPlay      = 2'd2,
      StResult    = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] ms_q, ms_d;
   logic [31:0] go_q, go_d;
   logic [3:0]  digit_q, digit_d;
   logic        run_q, run_d;
   logic        clear_q, clear_d;
   logic        piezo_en_q, piezo_en_d;
   logic [31:0] piezo_limit_q, piezo_limit_d;
   logic        enter_cd;

   // start only launches a game from IDLE/RESULT; restart works from anywhere
   always_comb begin
      enter_cd = 1'b0;
      case (state_q)
         StIdle, StResult: enter_cd = i_start | i_restart;
         default:          enter_cd = i_restart;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ms_d    = ms_q;
      go_d    = go_q;
      digit_d = digit_q;
      run_d   = run_q;
      clear_d = 1'b0;
      if (enter_cd) begin
         state_d = StCountdown;
         clear_d = 1'b1;
         digit_d = 4'(COUNT_STEPS);
         ms_d    = '0;
         run_d   = 1'b0;
      end else begin
         case (state_q)
            StCountdown: begin
               if (i_tick) begin
                  if (ms_q == COUNT_MS - 1) begin
                     ms_d = '0;
                     if (digit_q > 4'd1) begin
                        digit_d = digit_q - 4'd1;
                     end else begin
                        state_d = StPlay;
                        digit_d = '0;
                        run_d   = 1'b1;
                     end
                  end else begin
                     ms_d = ms_q + 32'd1;
                  end
               end
            end
            StPlay: begin
               if (i_game_end) begin
                  state_d = StResult;
                  run_d   = 1'b0;
                  go_d    = GO_MS;
               end
            end
            StResult: begin
               if (i_tick && go_q != '0) go_d = go_q - 32'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      piezo_en_d    = 1'b0;
      piezo_limit_d = '0;
      case (state_q)
         StCountdown: begin
            piezo_en_d    = (ms_q < BEEP_MS);
            piezo_limit_d = BEEP_LIMIT;
         end
         StPlay: begin
            piezo_en_d    = i_play_en;
            piezo_limit_d = i_cnt_limit;
         end
         StResult: begin
            piezo_en_d    = (go_q != '0);
            piezo_limit_d = GO_LIMIT;
         end
         default: ;
      endcase
      if (!piezo_en_d) piezo_limit_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ms_q          <= '0;
         go_q          <= '0;
         digit_q       <= '0;
         run_q         <= 1'b0;
         clear_q       <= 1'b0;
         piezo_en_q    <= 1'b0;
         piezo_limit_q <= '0;
      end else begin
         state_q       <= state_d;
         ms_q          <= ms_d;
         go_q          <= go_d;
         digit_q       <= digit_d;
         run_q         <= run_d;
         clear_q       <= clear_d;
         piezo_en_q    <= piezo_en_d;
         piezo_limit_q <= piezo_limit_d;
      end
   end

   assign o_state       = state_q;
   assign o_run         = run_q;
   assign o_clear       = clear_q;
   assign o_digit       = digit_q;
   assign o_piezo_en    = piezo_en_q;
   assign o_piezo_limit = piezo_limit_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by random traffic,
// all checked against a tick-counting reference model.
module tb_game_flow_ctrl;

   localparam int unsigned STEPS  = 3;
   localparam int unsigned CMS    = 10;
   localparam int unsigned BMS    = 2;
   localparam int unsigned GMS    = 5;
   localparam int unsigned BLIM   = 100;
   localparam int unsigned GLIM   = 50;

   logic        clk = 1'b0;
   logic        rst, i_tick, i_start, i_restart, i_game_end, i_play_en;
   logic [31:0] i_cnt_limit;
   logic [1:0]  o_state;
   logic        o_run, o_clear, o_piezo_en;
   logic [3:0]  o_digit;
   logic [31:0] o_piezo_limit;

   int checks   = 0;
   int failures = 0;

   // Model: state code, ticks since countdown entry, ticks since result entry
   int          m_state = 0;
   int          m_cd    = 0;
   int          m_go    = 0;
   logic        m_clear = 1'b0;
   logic        m_pen   = 1'b0;
   logic [31:0] m_plim  = '0;

   game_flow_ctrl #(
      .COUNT_STEPS(STEPS), .COUNT_MS(CMS), .BEEP_MS(BMS),
      .GO_MS(GMS), .BEEP_LIMIT(BLIM), .GO_LIMIT(GLIM)
   ) dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
      .i_restart(i_restart), .i_game_end(i_game_end), .i_play_en(i_play_en),
      .i_cnt_limit(i_cnt_limit), .o_state(o_state), .o_run(o_run),
      .o_clear(o_clear), .o_digit(o_digit), .o_piezo_en(o_piezo_en),
      .o_piezo_limit(o_piezo_limit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_edge(input logic r, st, rs, tk, ge, pe, input logic [31:0] cl);
      logic        pen_n;
      logic [31:0] plim_n;
      pen_n  = 1'b0;
      plim_n = '0;
      case (m_state)
         1: begin pen_n = ((m_cd % CMS) < BMS); plim_n = BLIM; end
         2: begin pen_n = pe; plim_n = cl; end
         3: begin pen_n = (m_go < GMS); plim_n = GLIM; end
         default: ;
      endcase
      if (!pen_n) plim_n = '0;
      if (r) begin
         m_state = 0; m_cd = 0; m_go = 0; m_clear = 0; m_pen = 0; m_plim = '0;
      end else begin
         m_pen   = pen_n;
         m_plim  = plim_n;
         m_clear = 1'b0;
         if (rs || (st && (m_state == 0 || m_state == 3))) begin
            m_state = 1; m_cd = 0; m_clear = 1'b1;
         end else if (m_state == 1 && tk) begin
            m_cd++;
            if (m_cd == STEPS * CMS) m_state = 2;
         end else if (m_state == 2 && ge) begin
            m_state = 3; m_go = 0;
         end else if (m_state == 3 && tk && m_go < GMS) begin
            m_go++;
         end
      end
   endtask

   task automatic check_all();
      int exp_digit;
      exp_digit = (m_state == 1) ? int'(STEPS) - m_cd / int'(CMS) : 0;
      chk("state", 32'(o_state), 32'(m_state));
      chk("run", 32'(o_run), 32'(m_state == 2));
      chk("clear", 32'(o_clear), 32'(m_clear));
      chk("digit", 32'(o_digit), 32'(exp_digit));
      chk("piezo_en", 32'(o_piezo_en), 32'(m_pen));
      chk("piezo_limit", o_piezo_limit, m_plim);
   endtask

   task automatic cycle(input logic r, st, rs, tk, ge, pe, input logic [31:0] cl);
      rst = r; i_start = st; i_restart = rs; i_tick = tk;
      i_game_end = ge; i_play_en = pe; i_cnt_limit = cl;
      @(posedge clk);
      model_edge(r, st, rs, tk, ge, pe, cl);
      #1;
      check_all();
   endtask

   task automatic idle_cycle();
      cycle(0, 0, 0, 0, 0, 0, 32'd0);
   endtask

   task automatic tick_cycle();
      cycle(0, 0, 0, 1, 0, 0, 32'd0);
   endtask

   initial begin
      // Reset
      cycle(1, 0, 0, 0, 0, 0, 32'd0);
      cycle(1, 0, 0, 1, 1, 1, 32'd777);
      chk("reset_state", 32'(o_state), 32'd0);
      chk("reset_limit", o_piezo_limit, 32'd0);
      idle_cycle();

      // Start from IDLE and run the full countdown
      cycle(0, 1, 0, 0, 0, 0, 32'd0);
      chk("start_state", 32'(o_state), 32'd1);
      chk("start_clear", 32'(o_clear), 32'd1);
      chk("start_digit", 32'(o_digit), 32'd3);
      idle_cycle();
      chk("clear_once", 32'(o_clear), 32'd0);
      chk("beep_first", 32'(o_piezo_en), 32'd1);
      chk("beep_limit", o_piezo_limit, 32'd100);
      for (int k = 1; k <= 30; k++) begin
         tick_cycle();
         if (k == 10) chk("digit_after10", 32'(o_digit), 32'd2);
         if (k == 20) chk("digit_after20", 32'(o_digit), 32'd1);
         if (k == 30) begin
            chk("play_state", 32'(o_state), 32'd2);
            chk("play_run", 32'(o_run), 32'd1);
            chk("play_digit", 32'(o_digit), 32'd0);
         end
         idle_cycle();
      end

      // Hit-sound pass-through
      cycle(0, 0, 0, 0, 0, 1, 32'd12345);
      chk("hit_en", 32'(o_piezo_en), 32'd1);
      chk("hit_limit", o_piezo_limit, 32'd12345);
      cycle(0, 0, 0, 0, 0, 0, 32'd12345);
      chk("hit_off_en", 32'(o_piezo_en), 32'd0);
      chk("hit_off_limit", o_piezo_limit, 32'd0);

      // start is ignored in PLAY; game end goes to RESULT
      cycle(0, 1, 0, 0, 0, 0, 32'd0);
      chk("start_in_play", 32'(o_state), 32'd2);
      cycle(0, 0, 0, 0, 1, 0, 32'd0);
      chk("result_state", 32'(o_state), 32'd3);
      chk("result_run", 32'(o_run), 32'd0);
      idle_cycle();
      chk("go_tone", o_piezo_limit, 32'd50);
      for (int k = 0; k < 7; k++) tick_cycle();
      idle_cycle();
      chk("go_silent", 32'(o_piezo_en), 32'd0);
      cycle(0, 1, 0, 0, 0, 0, 32'd0);
      chk("restart_from_result", 32'(o_state), 32'd1);
      chk("result_clear", 32'(o_clear), 32'd1);

      // start ignored in COUNTDOWN; restart beats game_end in PLAY
      tick_cycle();
      cycle(0, 1, 0, 0, 0, 0, 32'd0);
      chk("start_in_cd_state", 32'(o_state), 32'd1);
      chk("start_in_cd_clear", 32'(o_clear), 32'd0);
      for (int k = 0; k < 29; k++) tick_cycle();
      chk("play_again", 32'(o_state), 32'd2);
      cycle(0, 0, 1, 0, 1, 0, 32'd0);
      chk("restart_wins", 32'(o_state), 32'd1);
      chk("restart_clear", 32'(o_clear), 32'd1);

      // Restart inside COUNTDOWN reloads, then reset at digit 2
      for (int k = 0; k < 4; k++) tick_cycle();
      cycle(0, 1, 1, 1, 0, 0, 32'd0);
      chk("cd_restart_clear", 32'(o_clear), 32'd1);
      chk("cd_restart_digit", 32'(o_digit), 32'd3);
      for (int k = 0; k < 12; k++) tick_cycle();
      chk("digit_before_rst", 32'(o_digit), 32'd2);
      cycle(1, 0, 0, 1, 0, 0, 32'd0);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_digit", 32'(o_digit), 32'd0);
      chk("rst_clear", 32'(o_clear), 32'd0);

      // Stale game_end during COUNTDOWN is ignored
      cycle(0, 1, 0, 0, 1, 0, 32'd0);
      for (int k = 0; k < 15; k++) cycle(0, 0, 0, 1, 1, 0, 32'd0);
      chk("stale_game_end", 32'(o_state), 32'd1);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(199) == 0), ($urandom_range(39) == 0),
               ($urandom_range(59) == 0), ($urandom_range(1) == 0),
               ($urandom_range(7) == 0), 1'($urandom), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
